// File: rtl/shift_seq.sv
// Multi-cycle barrel shifter: rotate/shift a 16-bit operand by 0-15 using four
// fixed-latency binary-weighted stages (8, 4, 2, 1), one stage per clock.
module shift_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = 4;
  localparam int unsigned IdxW  = 2;
  localparam int unsigned AmtW  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [DataW-1:0]   work_q, work_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [DataW-1:0]   out_q, out_d;

  logic [AmtW-1:0]    amt_c;
  logic [DataW-1:0]   stage_c;

  // One stage of weight 2^idx applied to the working value.
  always_comb begin
    amt_c   = AmtW'(1) << idx_q;
    stage_c = work_q;
    case (op_q)
      2'b00:   stage_c = (work_q << amt_c) | (work_q >> (AmtW'(DataW) - amt_c));
      2'b01:   stage_c = work_q << amt_c;
      2'b10:   stage_c = (work_q >> amt_c) | (work_q << (AmtW'(DataW) - amt_c));
      default: stage_c = DataW'($signed(work_q) >>> amt_c);
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = in;
          cnt_d   = cnt;
          op_d    = op;
          idx_d   = IdxW'(3);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q[idx_q]) begin
          work_d = stage_c;
        end
        if (idx_q == IdxW'(0)) begin
          // Final stage result goes straight to out; latency never depends on cnt.
          out_d   = cnt_q[0] ? stage_c : work_q;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  // Status decoded from the state register only; no path from start.
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed vectors plus random operations
// compared against a bit-at-a-time behavioural model.
module tb_shift_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in_i;
  logic [3:0]  cnt_i;
  logic [1:0]  op_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] out_o;

  int pass_cnt;
  int total_cnt;

  shift_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in_i),
    .cnt   (cnt_i),
    .op    (op_i),
    .busy  (busy_o),
    .done  (done_o),
    .out   (out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: apply the operation one bit position at a time, n times.
  function automatic logic [15:0] model(input logic [15:0] v, input int n, input logic [1:0] o);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) begin
      case (o)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[0], r[15:1]};
        default: r = {r[15], r[15:1]};
      endcase
    end
    return r;
  endfunction

  // Drives one request from an idle DUT and observes 8 cycles afterwards.
  task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                        input bit scramble, output logic [15:0] res, output int busy_n,
                        output int done_at, output int done_n);
    @(negedge clk);
    in_i = a; cnt_i = c; op_i = o; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      in_i = 16'($urandom); cnt_i = 4'($urandom); op_i = 2'($urandom);
    end
    busy_n = 0; done_at = -1; done_n = 0; res = 16'hxxxx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busy_o) busy_n++;
      if (done_o) begin
        done_n++;
        done_at = k;
        res = out_o;
      end
      if (scramble && k == 2) begin
        start = 1'b1; in_i = ~a; cnt_i = ~c;
      end
      if (scramble && k == 3) start = 1'b0;
    end
  endtask

  task automatic check_op(input string name, input logic [15:0] a, input logic [3:0] c,
                          input logic [1:0] o, input bit scramble);
    logic [15:0] res, exp;
    int busy_n, done_at, done_n;
    exp = model(a, int'(c), o);
    run_op(a, c, o, scramble, res, busy_n, done_at, done_n);
    total_cnt++;
    if (res !== exp) $display("FAIL %s result: got %h expected %h", name, res, exp);
    else pass_cnt++;
    total_cnt++;
    if (busy_n !== 5) $display("FAIL %s busy_cycles: got %0d expected 5", name, busy_n);
    else pass_cnt++;
    total_cnt++;
    if (done_at !== 5 || done_n !== 1)
      $display("FAIL %s done_timing: got at=%0d n=%0d expected at=5 n=1", name, done_at, done_n);
    else pass_cnt++;
    total_cnt++;
    if (out_o !== exp) $display("FAIL %s out_hold: got %h expected %h", name, out_o, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; in_i = 16'hFFFF; cnt_i = 4'h3; op_i = 2'b01;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || out_o !== 16'h0000)
      $display("FAIL reset_state: got busy=%b done=%b out=%h expected 0 0 0000", busy_o, done_o, out_o);
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    check_op("rotl_1234_4", 16'h1234, 4'd4, 2'b00, 1'b0);
    check_op("sll_00ff_9", 16'h00FF, 4'd9, 2'b01, 1'b0);
    check_op("rotr_0001_1", 16'h0001, 4'd1, 2'b10, 1'b0);
    check_op("sra_8000_15", 16'h8000, 4'd15, 2'b11, 1'b0);
    check_op("sra_4000_15", 16'h4000, 4'd15, 2'b11, 1'b0);
  endtask

  task automatic test_cnt_zero();
    for (int o = 0; o < 4; o++) check_op("cnt_zero", 16'hA5A5, 4'd0, 2'(o), 1'b0);
  endtask

  task automatic test_mid_change();
    check_op("mid_change_a", 16'h8421, 4'd7, 2'b00, 1'b1);
    check_op("mid_change_b", 16'hC001, 4'd3, 2'b11, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_op("random", 16'($urandom), 4'($urandom), 2'($urandom), (i % 3) == 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int done_n, idle_ok;
    exp = model(16'h0F0F, 5, 2'b10);
    @(negedge clk);
    in_i = 16'h0F0F; cnt_i = 4'd5; op_i = 2'b10; start = 1'b1;
    done_n = 0; idle_ok = 1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (done_o) begin
        done_n++;
        total_cnt++;
        if (!(c == 5 || c == 11 || c == 17))
          $display("FAIL b2b_done_pos: got done at cycle %0d expected 5/11/17", c);
        else pass_cnt++;
        total_cnt++;
        if (out_o !== exp) $display("FAIL b2b_result: got %h expected %h", out_o, exp);
        else pass_cnt++;
      end
      if ((c == 6 || c == 12) && busy_o !== 1'b0) idle_ok = 0;
    end
    start = 1'b0;
    total_cnt++;
    if (done_n !== 3) $display("FAIL b2b_done_count: got %0d expected 3", done_n);
    else pass_cnt++;
    total_cnt++;
    if (idle_ok !== 1) $display("FAIL b2b_idle_gap: got busy in idle slot expected idle");
    else pass_cnt++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int done_n;
    check_op("pre_abort", 16'h1234, 4'd4, 2'b00, 1'b0);
    @(negedge clk);
    in_i = 16'hBEEF; cnt_i = 4'd6; op_i = 2'b01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || out_o !== 16'h0000)
      $display("FAIL abort_state: got busy=%b done=%b out=%h expected 0 0 0000", busy_o, done_o, out_o);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_o) done_n++;
    end
    total_cnt++;
    if (done_n !== 0 || out_o !== 16'h0000)
      $display("FAIL abort_no_done: got dones=%0d out=%h expected 0 0000", done_n, out_o);
    else pass_cnt++;
    check_op("post_abort", 16'h00FF, 4'd9, 2'b01, 1'b0);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; start = 1'b0; in_i = '0; cnt_i = '0; op_i = '0;
    test_reset();
    test_vectors();
    test_cnt_zero();
    test_mid_change();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
